// File: rtl/buffered_full_duplex_xbar.sv
// NumIn x NumOut crossbar with round-robin arbitration into per-target request FIFOs and
// per-initiator response FIFOs; each initiator is limited to MaxOutstanding in-flight requests.
module buffered_full_duplex_xbar #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned NumOut         = 4,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned ReqFifoDepth   = 2,
  parameter int unsigned RespFifoDepth  = 2,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned AW = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int unsigned IW = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int unsigned CW = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumIn-1:0]                  req_i,
  output logic [NumIn-1:0]                  gnt_o,
  input  logic [NumIn*AW-1:0]               add_i,
  input  logic [NumIn*ReqDataWidth-1:0]     wdata_i,
  output logic [NumIn-1:0]                  vld_o,
  input  logic [NumIn-1:0]                  rdy_i,
  output logic [NumIn*RespDataWidth-1:0]    rdata_o,
  output logic [NumOut-1:0]                 req_o,
  output logic [NumOut*IW-1:0]              idx_o,
  input  logic [NumOut-1:0]                 gnt_i,
  output logic [NumOut*ReqDataWidth-1:0]    wdata_o,
  input  logic [NumOut-1:0]                 vld_i,
  output logic [NumOut-1:0]                 rdy_o,
  input  logic [NumOut*IW-1:0]              idx_i,
  input  logic [NumOut*RespDataWidth-1:0]   rdata_i,
  output logic [NumIn*CW-1:0]               outstanding_o
);

  localparam int unsigned RQW = ReqDataWidth + IW;
  localparam int unsigned RQP = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned RQC = $clog2(ReqFifoDepth + 1);
  localparam int unsigned RSP = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam int unsigned RSC = $clog2(RespFifoDepth + 1);

  if (NumIn < 1 || NumOut < 1 || ReqFifoDepth < 1 || RespFifoDepth < 1 || MaxOutstanding < 1) begin : g_param_check
    $fatal(1, "buffered_full_duplex_xbar: all size parameters must be at least 1");
  end

  // Request side: one FIFO and one arbiter pointer per target.
  logic [RQW-1:0]    rq_mem_q     [NumOut][ReqFifoDepth];
  logic [RQP-1:0]    rq_wr_q      [NumOut];
  logic [RQP-1:0]    rq_wr_d      [NumOut];
  logic [RQP-1:0]    rq_rd_q      [NumOut];
  logic [RQP-1:0]    rq_rd_d      [NumOut];
  logic [RQC-1:0]    rq_cnt_q     [NumOut];
  logic [RQC-1:0]    rq_cnt_d     [NumOut];
  logic [IW-1:0]     rq_ptr_q     [NumOut];
  logic [IW-1:0]     rq_ptr_d     [NumOut];
  logic [RQW-1:0]    rq_push_data [NumOut];
  logic [NumOut-1:0] rq_push;
  logic [NumOut-1:0] rq_pop;

  // Response side: one FIFO and one arbiter pointer per initiator.
  logic [RespDataWidth-1:0] rs_mem_q     [NumIn][RespFifoDepth];
  logic [RSP-1:0]           rs_wr_q      [NumIn];
  logic [RSP-1:0]           rs_wr_d      [NumIn];
  logic [RSP-1:0]           rs_rd_q      [NumIn];
  logic [RSP-1:0]           rs_rd_d      [NumIn];
  logic [RSC-1:0]           rs_cnt_q     [NumIn];
  logic [RSC-1:0]           rs_cnt_d     [NumIn];
  logic [AW-1:0]            rs_ptr_q     [NumIn];
  logic [AW-1:0]            rs_ptr_d     [NumIn];
  logic [RespDataWidth-1:0] rs_push_data [NumIn];
  logic [NumIn-1:0]         rs_push;
  logic [NumIn-1:0]         rs_pop;

  logic [CW-1:0] out_cnt_q [NumIn];
  logic [CW-1:0] out_cnt_d [NumIn];

  function automatic logic [RQP-1:0] rq_inc(input logic [RQP-1:0] p);
    return (p == RQP'(ReqFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RSP-1:0] rs_inc(input logic [RSP-1:0] p);
    return (p == RSP'(RespFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scanning k downwards leaves the first eligible index at or after the pointer in win.
  always_comb begin : req_arb
    int            c;
    logic          win_vld;
    logic [IW-1:0] win;
    c       = 0;
    win_vld = 1'b0;
    win     = '0;
    gnt_o   = '0;
    for (int t = 0; t < int'(NumOut); t++) begin
      win_vld = 1'b0;
      win     = '0;
      for (int k = int'(NumIn) - 1; k >= 0; k--) begin
        c = (int'(rq_ptr_q[t]) + k) % int'(NumIn);
        if (req_i[c] && add_i[c*AW +: AW] == AW'(t) && out_cnt_q[c] < CW'(MaxOutstanding)) begin
          win_vld = 1'b1;
          win     = IW'(c);
        end
      end
      rq_pop[t]       = (rq_cnt_q[t] != '0) && gnt_i[t];
      rq_push[t]      = win_vld && (rq_cnt_q[t] != RQC'(ReqFifoDepth));
      rq_push_data[t] = {wdata_i[int'(win)*ReqDataWidth +: ReqDataWidth], win};
      if (rq_push[t]) gnt_o[win] = 1'b1;
      rq_ptr_d[t] = rq_push[t] ? IW'((int'(win) + 1) % int'(NumIn)) : rq_ptr_q[t];
      rq_wr_d[t]  = rq_push[t] ? rq_inc(rq_wr_q[t]) : rq_wr_q[t];
      rq_rd_d[t]  = rq_pop[t] ? rq_inc(rq_rd_q[t]) : rq_rd_q[t];
      rq_cnt_d[t] = rq_cnt_q[t] + RQC'(rq_push[t]) - RQC'(rq_pop[t]);
    end
  end

  always_comb begin : rsp_arb
    int            c;
    logic          win_vld;
    logic [AW-1:0] win;
    logic          inc;
    logic          dec;
    c       = 0;
    win_vld = 1'b0;
    win     = '0;
    inc     = 1'b0;
    dec     = 1'b0;
    rdy_o   = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      win_vld = 1'b0;
      win     = '0;
      for (int k = int'(NumOut) - 1; k >= 0; k--) begin
        c = (int'(rs_ptr_q[i]) + k) % int'(NumOut);
        if (vld_i[c] && idx_i[c*IW +: IW] == IW'(i)) begin
          win_vld = 1'b1;
          win     = AW'(c);
        end
      end
      rs_pop[i]       = (rs_cnt_q[i] != '0) && rdy_i[i];
      rs_push[i]      = win_vld && (rs_cnt_q[i] != RSC'(RespFifoDepth));
      rs_push_data[i] = rdata_i[int'(win)*RespDataWidth +: RespDataWidth];
      if (rs_push[i]) rdy_o[win] = 1'b1;
      rs_ptr_d[i] = rs_push[i] ? AW'((int'(win) + 1) % int'(NumOut)) : rs_ptr_q[i];
      rs_wr_d[i]  = rs_push[i] ? rs_inc(rs_wr_q[i]) : rs_wr_q[i];
      rs_rd_d[i]  = rs_pop[i] ? rs_inc(rs_rd_q[i]) : rs_rd_q[i];
      rs_cnt_d[i] = rs_cnt_q[i] + RSC'(rs_push[i]) - RSC'(rs_pop[i]);
      // A response with nothing in flight is a protocol error; the count holds instead of wrapping.
      inc = gnt_o[i] && (out_cnt_q[i] != CW'(MaxOutstanding));
      dec = rs_pop[i] && (out_cnt_q[i] != '0);
      out_cnt_d[i] = out_cnt_q[i];
      if (inc && !dec) out_cnt_d[i] = out_cnt_q[i] + 1'b1;
      else if (dec && !inc) out_cnt_d[i] = out_cnt_q[i] - 1'b1;
    end
  end

  always_comb begin : heads
    for (int t = 0; t < int'(NumOut); t++) begin
      req_o[t] = (rq_cnt_q[t] != '0);
      {wdata_o[t*ReqDataWidth +: ReqDataWidth], idx_o[t*IW +: IW]} = rq_mem_q[t][rq_rd_q[t]];
    end
    for (int i = 0; i < int'(NumIn); i++) begin
      vld_o[i] = (rs_cnt_q[i] != '0);
      rdata_o[i*RespDataWidth +: RespDataWidth] = rs_mem_q[i][rs_rd_q[i]];
      outstanding_o[i*CW +: CW] = out_cnt_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < int'(NumOut); t++) begin
        rq_wr_q[t]  <= '0;
        rq_rd_q[t]  <= '0;
        rq_cnt_q[t] <= '0;
        rq_ptr_q[t] <= '0;
      end
      for (int i = 0; i < int'(NumIn); i++) begin
        rs_wr_q[i]   <= '0;
        rs_rd_q[i]   <= '0;
        rs_cnt_q[i]  <= '0;
        rs_ptr_q[i]  <= '0;
        out_cnt_q[i] <= '0;
      end
    end else begin
      for (int t = 0; t < int'(NumOut); t++) begin
        rq_wr_q[t]  <= rq_wr_d[t];
        rq_rd_q[t]  <= rq_rd_d[t];
        rq_cnt_q[t] <= rq_cnt_d[t];
        rq_ptr_q[t] <= rq_ptr_d[t];
      end
      for (int i = 0; i < int'(NumIn); i++) begin
        rs_wr_q[i]   <= rs_wr_d[i];
        rs_rd_q[i]   <= rs_rd_d[i];
        rs_cnt_q[i]  <= rs_cnt_d[i];
        rs_ptr_q[i]  <= rs_ptr_d[i];
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy counters alone decide what is valid.
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < int'(NumOut); t++) begin
      if (rq_push[t]) rq_mem_q[t][rq_wr_q[t]] <= rq_push_data[t];
    end
    for (int i = 0; i < int'(NumIn); i++) begin
      if (rs_push[i]) rs_mem_q[i][rs_wr_q[i]] <= rs_push_data[i];
    end
  end

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_rsp_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(vld_o[gi] && rdy_i[gi] && out_cnt_q[gi] == '0));
  end

  for (genvar gt = 0; gt < NumOut; gt++) begin : g_idx_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(vld_i[gt] && int'(idx_i[gt*IW +: IW]) >= int'(NumIn)));
  end

endmodule

// File: tb/tb_buffered_full_duplex_xbar.sv
// Directed bench for buffered_full_duplex_xbar: single transfer, round-robin, backpressure,
// outstanding limit, response contention and asynchronous reset.
module tb_buffered_full_duplex_xbar;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int IW = 2;
  localparam int CW = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NI-1:0]     req_i;
  logic [NI-1:0]     gnt_o;
  logic [NI*AW-1:0]  add_i;
  logic [NI*DW-1:0]  wdata_i;
  logic [NI-1:0]     vld_o;
  logic [NI-1:0]     rdy_i;
  logic [NI*DW-1:0]  rdata_o;
  logic [NO-1:0]     req_o;
  logic [NO*IW-1:0]  idx_o;
  logic [NO-1:0]     gnt_i;
  logic [NO*DW-1:0]  wdata_o;
  logic [NO-1:0]     vld_i;
  logic [NO-1:0]     rdy_o;
  logic [NO*IW-1:0]  idx_i;
  logic [NO*DW-1:0]  rdata_i;
  logic [NI*CW-1:0]  outstanding_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [DW-1:0] exp_q [$];

  // Response-contention schedule, one entry per cycle.
  logic [4:0]    v0_seq = 5'b00111;
  logic [4:0]    v3_seq = 5'b01111;
  logic [DW-1:0] r0_dat [5] = '{32'hA0, 32'hA1, 32'hA1, 32'h0, 32'h0};
  logic [DW-1:0] r3_dat [5] = '{32'hD3, 32'hD3, 32'hD4, 32'hD4, 32'h0};
  logic [3:0]    rdy_exp [5] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0000};

  buffered_full_duplex_xbar #(
    .NumIn(NI), .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(DW),
    .ReqFifoDepth(2), .RespFifoDepth(2), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wdata_i(wdata_i),
    .vld_o(vld_o), .rdy_i(rdy_i), .rdata_o(rdata_o),
    .req_o(req_o), .idx_o(idx_o), .gnt_i(gnt_i), .wdata_o(wdata_o),
    .vld_i(vld_i), .rdy_o(rdy_o), .idx_i(idx_i), .rdata_i(rdata_i),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_i = '0; add_i = '0; wdata_i = '0; rdy_i = '0;
    gnt_i = '0; vld_i = '0; idx_i = '0; rdata_i = '0;
  endtask

  task automatic set_req(input int i, input int t, input logic [DW-1:0] d);
    req_i[i] = 1'b1;
    add_i[i*AW +: AW] = AW'(t);
    wdata_i[i*DW +: DW] = d;
  endtask

  task automatic set_rsp(input int t, input int i, input logic [DW-1:0] d);
    vld_i[t] = 1'b1;
    idx_i[t*IW +: IW] = IW'(i);
    rdata_i[t*DW +: DW] = d;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset state
    idle();
    rst_i = 1'b1;
    step();
    step();
    check_eq("rst_req_o", req_o, 4'b0000);
    check_eq("rst_vld_o", vld_o, 4'b0000);
    check_eq("rst_gnt_o", gnt_o, 4'b0000);
    check_eq("rst_rdy_o", rdy_o, 4'b0000);
    check_eq("rst_outst", outstanding_o, 12'h000);
    rst_i = 1'b0;
    step();

    // Single transfer: init 1 -> target 2 and back
    set_req(1, 2, 32'hA5);
    #1;
    check_eq("t1_gnt", gnt_o, 4'b0010);
    check_eq("t1_req_early", req_o, 4'b0000);
    step();
    idle();
    gnt_i[2] = 1'b1;
    #1;
    check_eq("t1_req_o", req_o, 4'b0100);
    check_eq("t1_idx_o", idx_o[2*IW +: IW], 2'd1);
    check_eq("t1_wdata_o", wdata_o[2*DW +: DW], 32'hA5);
    check_eq("t1_outst1", outstanding_o[1*CW +: CW], 3'd1);
    check_eq("t1_gnt_idle", gnt_o, 4'b0000);
    step();
    idle();
    #1;
    check_eq("t1_req_pop", req_o, 4'b0000);
    set_rsp(2, 1, 32'h3C);
    #1;
    check_eq("t1_rdy_o", rdy_o, 4'b0100);
    check_eq("t1_vld_early", vld_o, 4'b0000);
    step();
    idle();
    rdy_i[1] = 1'b1;
    #1;
    check_eq("t1_vld_o", vld_o, 4'b0010);
    check_eq("t1_rdata_o", rdata_o[1*DW +: DW], 32'h3C);
    check_eq("t1_outst_hold", outstanding_o[1*CW +: CW], 3'd1);
    step();
    idle();
    #1;
    check_eq("t1_vld_done", vld_o, 4'b0000);
    check_eq("t1_outst0", outstanding_o, 12'h000);

    // Round-robin: all initiators to target 0, target always ready
    for (int k = 0; k < 5; k++) begin
      idle();
      for (int i = 0; i < NI; i++) set_req(i, 0, 32'h10 + 32'(i));
      gnt_i[0] = 1'b1;
      #1;
      check_eq($sformatf("rr_gnt%0d", k), gnt_o, 4'b0001 << (k % 4));
      step();
    end
    idle();
    gnt_i[0] = 1'b1;
    #1;
    check_eq("rr_last_entry", req_o, 4'b0001);
    step();
    idle();
    #1;
    check_eq("rr_drained", req_o, 4'b0000);
    check_eq("rr_outst", outstanding_o, 12'h24A);

    // Backpressure: target 0 stalled, depth 2
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      set_req(0, 0, 32'h100 + 32'(k));
      #1;
      check_eq($sformatf("bp_gnt%0d", k), gnt_o, (k < 2) ? 4'b0001 : 4'b0000);
      if (k < 2) exp_q.push_back(32'h100 + 32'(k));
      if (k > 0) begin
        check_eq($sformatf("bp_req%0d", k), req_o[0], 1'b1);
        check_eq($sformatf("bp_head%0d", k), wdata_o[0 +: DW], 32'h100);
      end
      step();
    end
    idle();
    #1;
    check_eq("bp_outst", outstanding_o[0 +: CW], 3'd2);
    for (int c = 0; c < 6; c++) begin
      idle();
      gnt_i[0] = 1'b1;
      #1;
      if (req_o[0]) begin
        if (exp_q.size() == 0) check_eq("bp_extra", req_o[0], 1'b0);
        else check_eq($sformatf("bp_drain%0d", c), wdata_o[0 +: DW], exp_q.pop_front());
      end
      step();
    end
    check_eq("bp_left", exp_q.size(), 0);
    check_eq("bp_empty", req_o, 4'b0000);

    // Outstanding limit: no responses, target 1 always ready
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle();
      set_req(0, 1, 32'h200 + 32'(k));
      gnt_i[1] = 1'b1;
      #1;
      check_eq($sformatf("ol_gnt%0d", k), gnt_o, (k < 4) ? 4'b0001 : 4'b0000);
      step();
    end
    check_eq("ol_outst4", outstanding_o[0 +: CW], 3'd4);
    set_rsp(1, 0, 32'h77);
    rdy_i[0] = 1'b1;
    #1;
    check_eq("ol_rsp_rdy", rdy_o, 4'b0010);
    check_eq("ol_gnt_blocked", gnt_o, 4'b0000);
    step();
    vld_i = '0;
    #1;
    check_eq("ol_vld_o", vld_o, 4'b0001);
    check_eq("ol_rdata", rdata_o[0 +: DW], 32'h77);
    check_eq("ol_gnt_still", gnt_o, 4'b0000);
    step();
    #1;
    check_eq("ol_outst3", outstanding_o[0 +: CW], 3'd3);
    check_eq("ol_gnt5", gnt_o, 4'b0001);
    step();
    #1;
    check_eq("ol_outst_back4", outstanding_o[0 +: CW], 3'd4);
    check_eq("ol_gnt_after", gnt_o, 4'b0000);
    idle();
    step();

    // Response contention: targets 0 and 3 both return to initiator 2
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      set_req(2, 0, 32'h300 + 32'(k));
      gnt_i[0] = 1'b1;
      step();
    end
    idle();
    gnt_i[0] = 1'b1;
    step();
    check_eq("rc_outst", outstanding_o[2*CW +: CW], 3'd4);
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'hD3);
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hD4);
    for (int k = 0; k < 5; k++) begin
      idle();
      rdy_i[2] = 1'b1;
      if (v0_seq[k]) set_rsp(0, 2, r0_dat[k]);
      if (v3_seq[k]) set_rsp(3, 2, r3_dat[k]);
      #1;
      check_eq($sformatf("rc_rdy%0d", k), rdy_o, rdy_exp[k]);
      if (k > 0) begin
        check_eq($sformatf("rc_vld%0d", k), vld_o, 4'b0100);
        check_eq($sformatf("rc_data%0d", k), rdata_o[2*DW +: DW], exp_q.pop_front());
      end else begin
        check_eq("rc_vld0", vld_o, 4'b0000);
      end
      step();
    end
    idle();
    #1;
    check_eq("rc_vld_end", vld_o, 4'b0000);
    check_eq("rc_outst_end", outstanding_o, 12'h000);

    // Asynchronous reset with buffered traffic
    set_req(0, 0, 32'hE0);
    set_req(1, 1, 32'hE1);
    set_rsp(2, 0, 32'h55);
    #1;
    step();
    idle();
    #1;
    check_eq("ar_pre_req", req_o, 4'b0011);
    check_eq("ar_pre_vld", vld_o, 4'b0001);
    check_eq("ar_pre_outst", outstanding_o[0 +: CW], 3'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("ar_req_o", req_o, 4'b0000);
    check_eq("ar_vld_o", vld_o, 4'b0000);
    check_eq("ar_outst", outstanding_o, 12'h000);
    #1;
    rst_i = 1'b0;
    step();
    for (int i = 0; i < NI; i++) set_req(i, 0, 32'hF0 + 32'(i));
    gnt_i[0] = 1'b1;
    #1;
    check_eq("ar_first_gnt", gnt_o, 4'b0001);
    step();
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
